// File: rtl/pat_checker.sv
// Receive-side pattern frame checker.
// Checks every beat against framing rules and reports per-frame error flags.
module pat_checker #(
  parameter int PATTERN_WIDTH  = 32,
  parameter int DATA_WIDTH     = 64,
  parameter int CYCLES_PER_ROW = 4,
  parameter int ROWS_PER_FRAME = 3
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     clear,
  input  logic [DATA_WIDTH-1:0]    AXIS_IN_TDATA,
  input  logic                     AXIS_IN_TVALID,
  input  logic                     AXIS_IN_TLAST,
  output logic                     AXIS_IN_TREADY,
  output logic [PATTERN_WIDTH-1:0] AXIS_RPT_TDATA,
  output logic [2:0]               AXIS_RPT_TUSER,
  output logic                     AXIS_RPT_TVALID,
  input  logic                     AXIS_RPT_TREADY,
  output logic [31:0]              frame_count,
  output logic [31:0]              error_count
);

  localparam int L = DATA_WIDTH / PATTERN_WIDTH;

  typedef enum logic [1:0] {
    FIRST,
    BODY,
    REPORT
  } state_t;

  state_t state, state_nxt;

  logic [PATTERN_WIDTH-1:0] pattern;
  logic [PATTERN_WIDTH-1:0] lane0;
  logic [PATTERN_WIDTH-1:0] pat_nxt;
  logic [2:0]  flags;
  logic [2:0]  flags_nxt;
  logic [31:0] beat_idx;
  logic [31:0] row_idx;
  logic accept;
  logic rpt_fire;
  logic rep_hit;
  logic mis_hit;
  logic last_idx;
  logic tl_hit;
  logic row_end;
  logic frame_end;

  assign AXIS_IN_TREADY = resetn & (state != REPORT);
  assign accept   = AXIS_IN_TVALID & AXIS_IN_TREADY;
  assign rpt_fire = AXIS_RPT_TVALID & AXIS_RPT_TREADY;
  assign lane0    = AXIS_IN_TDATA[PATTERN_WIDTH-1:0];

  always_comb begin
    rep_hit = 1'b0;
    for (int k = 1; k < L; k++) begin
      if (AXIS_IN_TDATA[k*PATTERN_WIDTH +: PATTERN_WIDTH] != lane0)
        rep_hit = 1'b1;
    end
  end

  assign mis_hit   = (state == BODY) && (lane0 != pattern);
  assign last_idx  = beat_idx == 32'(CYCLES_PER_ROW - 1);
  // TLAST must coincide exactly with the last beat slot of a row
  assign tl_hit    = AXIS_IN_TLAST ^ last_idx;
  assign row_end   = AXIS_IN_TLAST | last_idx;
  assign frame_end = accept & row_end &
                     (row_idx == 32'(ROWS_PER_FRAME - 1));
  assign pat_nxt   = (state == FIRST) ? lane0 : pattern;
  assign flags_nxt = ((state == FIRST) ? 3'b000 : flags) |
                     {tl_hit, mis_hit, rep_hit};

  always_ff @(posedge clk) begin
    if (!resetn) state <= FIRST;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      FIRST:  if (accept) state_nxt = frame_end ? REPORT : BODY;
      BODY:   if (frame_end) state_nxt = REPORT;
      REPORT: if (rpt_fire) state_nxt = FIRST;
      default: state_nxt = FIRST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pattern         <= '0;
      flags           <= '0;
      beat_idx        <= '0;
      row_idx         <= '0;
      AXIS_RPT_TDATA  <= '0;
      AXIS_RPT_TUSER  <= '0;
      AXIS_RPT_TVALID <= 1'b0;
      frame_count     <= '0;
      error_count     <= '0;
    end else begin
      if (accept) begin
        pattern <= pat_nxt;
        flags   <= flags_nxt;
        if (frame_end) begin
          beat_idx <= '0;
          row_idx  <= '0;
        end else if (row_end) begin
          beat_idx <= '0;
          row_idx  <= row_idx + 32'd1;
        end else begin
          beat_idx <= beat_idx + 32'd1;
        end
      end
      if (frame_end) begin
        AXIS_RPT_TDATA  <= pat_nxt;
        AXIS_RPT_TUSER  <= flags_nxt;
        AXIS_RPT_TVALID <= 1'b1;
      end else if (rpt_fire) begin
        AXIS_RPT_TVALID <= 1'b0;
      end
      // clear wins over a same-cycle frame-end increment
      if (clear) begin
        frame_count <= '0;
        error_count <= '0;
      end else if (frame_end) begin
        frame_count <= frame_count + 32'd1;
        if (|flags_nxt && error_count != 32'hFFFF_FFFF)
          error_count <= error_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_pat_checker.sv
// Directed testbench for pat_checker.
// Each task drives one scenario and checks outputs inline.
module tb_pat_checker;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        clear = 1'b0;
  logic [63:0] din = '0;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;
  logic        in_tready;
  logic [31:0] rpt_tdata;
  logic [2:0]  rpt_tuser;
  logic        rpt_tvalid;
  logic        rpt_tready = 1'b1;
  logic [31:0] frame_count;
  logic [31:0] error_count;

  int checks = 0;
  int failures = 0;
  int exp_fc = 0;
  int exp_ec = 0;

  localparam logic [31:0] PAT = 32'hA5A5_0001;

  pat_checker dut (
    .clk(clk),
    .resetn(resetn),
    .clear(clear),
    .AXIS_IN_TDATA(din),
    .AXIS_IN_TVALID(tvalid),
    .AXIS_IN_TLAST(tlast),
    .AXIS_IN_TREADY(in_tready),
    .AXIS_RPT_TDATA(rpt_tdata),
    .AXIS_RPT_TUSER(rpt_tuser),
    .AXIS_RPT_TVALID(rpt_tvalid),
    .AXIS_RPT_TREADY(rpt_tready),
    .frame_count(frame_count),
    .error_count(error_count)
  );

  always #5 clk = ~clk;

  task automatic send_beat(input logic [31:0] a, input logic [31:0] b,
                           input logic last, input logic clr);
    int waited;
    @(negedge clk);
    din = {b, a};
    tlast = last;
    tvalid = 1'b1;
    clear = clr;
    waited = 0;
    while (!in_tready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) begin
      checks++;
      failures++;
      $display("FAIL beat_timeout waited=%0d limit=50", waited);
    end
    @(posedge clk);
  endtask

  // mode: 0 clean, 1 lane corrupt, 2 pattern change, 3 early tlast, 4 missing tlast
  task automatic run_frame(input int n, input int mode, input bit clr_last,
                           input int first_b);
    logic [31:0] a, c;
    logic last;
    for (int b = first_b; b <= n; b++) begin
      a = PAT;
      c = PAT;
      last = (b % 4 == 0);
      if (mode == 1 && b == 5) c = 32'hDEAD_BEEF;
      if (mode == 2 && b == 7) begin
        a = 32'h1111_2222;
        c = a;
      end
      if (mode == 3) last = (b == 2 || b == 6 || b == 10);
      if (mode == 4 && b == 4) last = 1'b0;
      send_beat(a, c, last, clr_last && b == n);
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (in_tready !== 1'b0) begin
      failures++; $display("FAIL rst_tready got=%b exp=0", in_tready);
    end
    checks++;
    if (rpt_tvalid !== 1'b0 || rpt_tdata !== 32'h0 || rpt_tuser !== 3'b000) begin
      failures++;
      $display("FAIL rst_rpt got=%b/%h/%b exp=0/0/000", rpt_tvalid, rpt_tdata, rpt_tuser);
    end
    checks++;
    if (frame_count !== 32'd0 || error_count !== 32'd0) begin
      failures++;
      $display("FAIL rst_counts got=%0d/%0d exp=0/0", frame_count, error_count);
    end
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (in_tready !== 1'b1) begin
      failures++; $display("FAIL rst_release_tready got=%b exp=1", in_tready);
    end
  endtask

  // Checks the report the cycle after the final beat, then the following cycle.
  task automatic check_after_frame(input string nm, input logic [2:0] tu);
    @(negedge clk);
    tvalid = 1'b0;
    clear = 1'b0;
    checks++;
    if (rpt_tvalid !== 1'b1 || rpt_tdata !== PAT || rpt_tuser !== tu) begin
      failures++;
      $display("FAIL %s_rpt got=%b/%h/%b exp=1/%h/%b",
               nm, rpt_tvalid, rpt_tdata, rpt_tuser, PAT, tu);
    end
    checks++;
    if (frame_count !== 32'(exp_fc) || error_count !== 32'(exp_ec)) begin
      failures++;
      $display("FAIL %s_counts got=%0d/%0d exp=%0d/%0d",
               nm, frame_count, error_count, exp_fc, exp_ec);
    end
    checks++;
    if (in_tready !== 1'b0) begin
      failures++; $display("FAIL %s_bubble got=%b exp=0", nm, in_tready);
    end
    @(negedge clk);
    checks++;
    if (in_tready !== 1'b1 || rpt_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL %s_resume got=%b/%b exp=1/0", nm, in_tready, rpt_tvalid);
    end
  endtask

  task automatic test_clean;
    run_frame(12, 0, 1'b0, 1);
    exp_fc = 1; exp_ec = 0;
    check_after_frame("clean", 3'b000);
  endtask

  task automatic test_lane_corrupt;
    run_frame(12, 1, 1'b0, 1);
    exp_fc = 2; exp_ec = 1;
    check_after_frame("lane", 3'b001);
    run_frame(12, 0, 1'b0, 1);
    exp_fc = 3;
    check_after_frame("lane_next", 3'b000);
  endtask

  task automatic test_pattern_change;
    run_frame(12, 2, 1'b0, 1);
    exp_fc = 4; exp_ec = 2;
    check_after_frame("patchg", 3'b010);
  endtask

  task automatic test_tlast;
    run_frame(10, 3, 1'b0, 1);
    exp_fc = 5; exp_ec = 3;
    check_after_frame("early", 3'b100);
    run_frame(12, 4, 1'b0, 1);
    exp_fc = 6; exp_ec = 4;
    check_after_frame("missing", 3'b100);
  endtask

  task automatic test_back_to_back;
    logic [31:0] td;
    logic [2:0]  tu;
    int acc;
    int unstable;
    rpt_tready = 1'b0;
    run_frame(12, 0, 1'b0, 1);
    exp_fc = 7;
    @(negedge clk);
    din = {PAT, PAT};
    tlast = 1'b0;
    tvalid = 1'b1;
    td = rpt_tdata;
    tu = rpt_tuser;
    acc = 0;
    unstable = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      if (in_tready) acc++;
      if (rpt_tvalid !== 1'b1 || rpt_tdata !== td || rpt_tuser !== tu)
        unstable++;
    end
    checks++;
    if (acc != 0) begin
      failures++; $display("FAIL bp_accepted got=%0d exp=0", acc);
    end
    checks++;
    if (unstable != 0 || td !== PAT || tu !== 3'b000) begin
      failures++;
      $display("FAIL bp_stable got=%0d/%h/%b exp=0/%h/000", unstable, td, tu, PAT);
    end
    checks++;
    if (frame_count !== 32'(exp_fc)) begin
      failures++; $display("FAIL bp_fc got=%0d exp=%0d", frame_count, exp_fc);
    end
    rpt_tready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_tready !== 1'b1 || rpt_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL bp_handshake got=%b/%b exp=1/0", in_tready, rpt_tvalid);
    end
    @(posedge clk);
    run_frame(12, 0, 1'b0, 2);
    exp_fc = 8;
    check_after_frame("bp_next", 3'b000);
  endtask

  task automatic test_reset_clear;
    run_frame(6, 0, 1'b0, 1);
    @(negedge clk);
    tvalid = 1'b0;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (rpt_tvalid !== 1'b0 || frame_count !== 32'd0 || error_count !== 32'd0) begin
      failures++;
      $display("FAIL abort got=%b/%0d/%0d exp=0/0/0", rpt_tvalid, frame_count, error_count);
    end
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (rpt_tvalid !== 1'b0) begin
      failures++; $display("FAIL abort_norpt got=%b exp=0", rpt_tvalid);
    end
    run_frame(12, 0, 1'b0, 1);
    exp_fc = 1; exp_ec = 0;
    check_after_frame("post_rst", 3'b000);
    run_frame(12, 1, 1'b1, 1);
    exp_fc = 0; exp_ec = 0;
    check_after_frame("clear", 3'b001);
  endtask

  initial begin
    test_reset();
    test_clean();
    test_lane_corrupt();
    test_pattern_change();
    test_tlast();
    test_back_to_back();
    test_reset_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
